instr_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of the `mips` datapath's decode. It owns the fetch program counter and issues one-word reads to a synchronous instruction memory. Returned words are buffered, with their PCs, in a small prefetch queue. The queue is drained by decode over a valid/ready handshake, and decode can redirect fetch on taken branches and jumps.

---
 rtl/instr_fetch_if.sv | 37 +++
 rtl/instr_fetch.sv | 100 ++++++++++
 tb/tb_instr_fetch.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-side bundle: instruction memory read port
// plus the decode valid/ready and redirect signals.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  redirect,
    input  redirect_pc,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output redirect,
    output redirect_pc,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues
// one-word reads and buffers returns in a prefetch queue.
module instr_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst,
  instr_fetch_if.master  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          q_mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     fetch_pc;
  logic            inflight;
  logic [31:0]     inflight_pc;

  logic [CW:0]     occupancy;
  logic            req;
  logic            push;
  logic            pop;
  logic            valid;
  logic [31:0]     redir_pc;

  // Every in-flight read already owns a queue slot, so a
  // request is only allowed while slots remain unclaimed.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign req       = !rst && !bus.redirect
                   && (occupancy < DEPTH_W);
  assign push      = inflight && !bus.redirect;
  assign valid     = (count != '0);
  assign pop       = valid && bus.instr_ready;
  assign redir_pc  = {bus.redirect_pc[31:2], 2'b00};

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = valid;
  assign bus.instr       = q_mem[rd_ptr].instr;
  assign bus.instr_pc    = q_mem[rd_ptr].pc;

  // Fetch PC and in-flight tracking; redirect restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else if (bus.redirect) begin
      fetch_pc    <= redir_pc;
      inflight    <= 1'b0;
    end else if (req) begin
      fetch_pc    <= fetch_pc + 32'd4;
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
    end else begin
      inflight    <= 1'b0;
    end
  end

  // Queue pointers and count; redirect flushes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Queue storage: returned word tagged with its PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        q_mem[i] <= '0;
    end else if (push) begin
      q_mem[wr_ptr] <= '{pc: inflight_pc,
                         instr: bus.imem_rdata};
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based reference model
// checked every cycle, plus directed literal checks.
module tb_instr_fetch;

  localparam int DEPTH = 4;
  localparam logic [31:0] RP0 = 32'h0000_0000;
  localparam logic [31:0] RP1 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ready = 1'b0;
  logic [31:0] key = 32'h0;
  logic [31:0] rdata0 = 32'h0;
  logic [31:0] rdata1 = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_if bus0 ();
  instr_fetch_if bus1 ();

  assign bus0.imem_rdata  = rdata0;
  assign bus0.redirect    = redirect;
  assign bus0.redirect_pc = redirect_pc;
  assign bus0.instr_ready = ready;
  assign bus1.imem_rdata  = rdata1;
  assign bus1.redirect    = redirect;
  assign bus1.redirect_pc = redirect_pc;
  assign bus1.instr_ready = ready;

  instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RP0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RP1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  // Synchronous memory: word = address ^ key, one cycle later.
  always @(posedge clk) begin
    rdata0 <= bus0.imem_req ? (bus0.imem_addr ^ key) : $urandom;
    rdata1 <= bus1.imem_req ? (bus1.imem_addr ^ key) : $urandom;
  end

  logic        a_req   [2];
  logic [31:0] a_addr  [2];
  logic        a_valid [2];
  logic [31:0] a_instr [2];
  logic [31:0] a_pc    [2];
  assign a_req[0]   = bus0.imem_req;
  assign a_addr[0]  = bus0.imem_addr;
  assign a_valid[0] = bus0.instr_valid;
  assign a_instr[0] = bus0.instr;
  assign a_pc[0]    = bus0.instr_pc;
  assign a_req[1]   = bus1.imem_req;
  assign a_addr[1]  = bus1.imem_addr;
  assign a_valid[1] = bus1.instr_valid;
  assign a_instr[1] = bus1.instr;
  assign a_pc[1]    = bus1.instr_pc;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: fetch PC, one pending read, and a
  // queue of {pc, word} pairs.
  logic [31:0] mpc     [2];
  logic        minf    [2];
  logic [31:0] minf_pc [2];
  logic [63:0] mq      [2][$];

  function automatic logic [31:0] rp(input int i);
    return (i == 0) ? RP0 : RP1;
  endfunction

  task automatic model_cycle(input int i);
    logic        er;
    logic        ev;
    logic [63:0] hd;
    if (rst) begin
      mpc[i]  = rp(i);
      minf[i] = 1'b0;
      mq[i].delete();
    end
    er = !rst && !redirect
       && ((mq[i].size() + int'(minf[i])) < DEPTH);
    ev = (mq[i].size() != 0);
    chk($sformatf("d%0d_req", i), 32'(a_req[i]), 32'(er));
    chk($sformatf("d%0d_valid", i), 32'(a_valid[i]), 32'(ev));
    if (er || rst)
      chk($sformatf("d%0d_addr", i), a_addr[i], mpc[i]);
    if (ev) begin
      hd = mq[i][0];
      chk($sformatf("d%0d_pc", i), a_pc[i], hd[63:32]);
      chk($sformatf("d%0d_instr", i), a_instr[i], hd[31:0]);
    end
    if (!rst) begin
      if (redirect) begin
        mpc[i]  = {redirect_pc[31:2], 2'b00};
        minf[i] = 1'b0;
        mq[i].delete();
      end else begin
        if (ev && ready)
          void'(mq[i].pop_front());
        if (minf[i])
          mq[i].push_back({minf_pc[i], minf_pc[i] ^ key});
        if (er) begin
          minf[i]    = 1'b1;
          minf_pc[i] = mpc[i];
          mpc[i]     = mpc[i] + 32'd4;
        end else begin
          minf[i] = 1'b0;
        end
      end
    end
  endtask

  // Compare both DUTs against the model every cycle.
  always @(negedge clk) begin
    model_cycle(0);
    model_cycle(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
  endtask

  // Leaves the bench at the start of cycle C0.
  task automatic reset_pulse(input int n);
    rst = 1'b1;
    repeat (n) begin
      peek();
      chk("rst_req", 32'(bus0.imem_req), 32'd0);
      chk("rst_valid", 32'(bus0.instr_valid), 32'd0);
      chk("rst_addr", bus0.imem_addr, RP0);
      chk("rst_addr1", bus1.imem_addr, RP1);
      step();
    end
    rst = 1'b0;
  endtask

  logic [31:0] seen[$];

  initial begin
    // Reset release and streaming
    ready = 1'b1;
    key   = 32'h0;
    #1;
    reset_pulse(2);
    peek();
    chk("c0_req", 32'(bus0.imem_req), 32'd1);
    chk("c0_addr", bus0.imem_addr, 32'h0);
    chk("c0_addr1", bus1.imem_addr, RP1);
    step(); peek();
    chk("c1_valid", 32'(bus0.instr_valid), 32'd0);
    step(); peek();
    chk("c2_valid", 32'(bus0.instr_valid), 32'd1);
    chk("c2_instr", bus0.instr, 32'h0);
    chk("c2_pc", bus0.instr_pc, 32'h0);
    chk("c2_pc1", bus1.instr_pc, 32'hFFFF_FFF8);
    for (int k = 1; k < 20; k++) begin
      step(); peek();
      chk("strm_valid", 32'(bus0.instr_valid), 32'd1);
      chk("strm_pc", bus0.instr_pc, 32'(k * 4));
      chk("strm_instr", bus0.instr, 32'(k * 4));
      if (k == 1) chk("wrap_pc1", bus1.instr_pc, 32'hFFFF_FFFC);
      if (k == 2) chk("wrap_pc2", bus1.instr_pc, 32'h0000_0000);
      if (k == 3) chk("wrap_pc3", bus1.instr_pc, 32'h0000_0004);
    end
    step();

    // Stall from reset, then drain
    ready = 1'b0;
    reset_pulse(1);
    seen.delete();
    for (int c = 0; c < 10; c++) begin
      peek();
      if (bus0.imem_req) seen.push_back(bus0.imem_addr);
      step();
    end
    chk("stall_nreq", 32'(seen.size()), 32'd4);
    for (int j = 0; j < seen.size() && j < 4; j++)
      chk("stall_addr", seen[j], 32'(j * 4));
    peek();
    chk("stall_head", bus0.instr_pc, 32'h0);
    step();
    ready = 1'b1;
    seen.delete();
    for (int c = 0; c < 12 && seen.size() < 5; c++) begin
      peek();
      if (bus0.instr_valid) seen.push_back(bus0.instr_pc);
      step();
    end
    chk("drain_n", 32'(seen.size()), 32'd5);
    for (int j = 0; j < seen.size() && j < 5; j++)
      chk("drain_pc", seen[j], 32'(j * 4));

    // Redirect while the read of 0x8 is in flight
    reset_pulse(1);
    step(); step(); step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    peek();
    chk("redir_noreq", 32'(bus0.imem_req), 32'd0);
    step();
    redirect    = 1'b0;
    redirect_pc = $urandom;
    peek();
    chk("r1_req", 32'(bus0.imem_req), 32'd1);
    chk("r1_addr", bus0.imem_addr, 32'h100);
    chk("r1_valid", 32'(bus0.instr_valid), 32'd0);
    step(); peek();
    chk("r2_valid", 32'(bus0.instr_valid), 32'd0);
    step(); peek();
    chk("r3_valid", 32'(bus0.instr_valid), 32'd1);
    chk("r3_pc", bus0.instr_pc, 32'h100);
    step(); peek();
    chk("r4_pc", bus0.instr_pc, 32'h104);
    step();

    // Reset with three entries queued
    ready = 1'b0;
    reset_pulse(1);
    step(); step(); step(); step();
    peek();
    chk("pre_valid", 32'(bus0.instr_valid), 32'd1);
    step();
    rst = 1'b1;
    peek();
    chk("mid_valid", 32'(bus0.instr_valid), 32'd0);
    chk("mid_req", 32'(bus0.imem_req), 32'd0);
    step();
    rst   = 1'b0;
    ready = 1'b1;
    peek();
    chk("rel_c0_req", 32'(bus0.imem_req), 32'd1);
    chk("rel_c0_addr", bus0.imem_addr, 32'h0);
    step(); peek();
    chk("rel_c1_valid", 32'(bus0.instr_valid), 32'd0);
    step(); peek();
    chk("rel_c2_valid", 32'(bus0.instr_valid), 32'd1);
    chk("rel_c2_pc", bus0.instr_pc, 32'h0);
    step();

    // Randomized traffic, model-checked every cycle
    key = $urandom;
    reset_pulse(1);
    for (int c = 0; c < 1500; c++) begin
      ready       = ($urandom % 4) != 0;
      redirect    = ($urandom % 16) == 0;
      redirect_pc = $urandom;
      rst         = ($urandom % 120) == 0;
      if (c % 300 == 0) ready = 1'b0;
      step();
    end
    rst      = 1'b0;
    redirect = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
